// File: rtl/uart_port_switch.sv
// Runtime-selectable UART line switch: one host UART bridged to one of N_PORTS ports.
// Latency: 3 clk edges from any rx input to its bridged tx output (2 sync flops + output register).
// No backpressure: port changes wait for both connected lines to idle, then force a high guard gap.
module uart_port_switch #(
  parameter int N_PORTS     = 4,
  parameter int SEL_W       = 2,
  parameter int IDLE_CYCLES = 16,
  parameter int GAP_CYCLES  = 4,
  parameter int ACT_CYCLES  = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               host_rx_i,
  output logic               host_tx_o,
  input  logic [N_PORTS-1:0] port_rx_i,
  output logic [N_PORTS-1:0] port_tx_o,
  input  logic [SEL_W-1:0]   sel_i,
  output logic [SEL_W-1:0]   cur_o,
  output logic               cur_valid_o,
  output logic               busy_o,
  output logic               act_o
);

  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int AW = $clog2(ACT_CYCLES + 1);

  typedef enum logic [1:0] {CONNECTED, DRAIN, GAP} state_t;

  state_t             state, state_n;
  logic [SEL_W-1:0]   cur, cur_n, pending, pending_n;
  logic [IW-1:0]      idle_cnt, idle_n;
  logic [GW-1:0]      gap_cnt, gap_n;
  logic [AW-1:0]      act_cnt, act_n;

  logic               host_m, host_s, host_prev;
  logic [N_PORTS-1:0] port_m, port_s, port_prev;
  logic [SEL_W-1:0]   sel_m, sel_s;

  logic               conn, conn_prev, both_idle, fall;
  logic               host_tx_n;
  logic [N_PORTS-1:0] port_tx_n;

  // Line of the selected port; an out-of-range selection reads as an idle (high) line.
  function automatic logic line_of(input logic [SEL_W-1:0] p, input logic [N_PORTS-1:0] v);
    logic r;
    r = 1'b1;
    for (int k = 0; k < N_PORTS; k++) begin
      if (p == SEL_W'(k)) r = v[k];
    end
    return r;
  endfunction

  // Two-flop synchronisers plus one history stage for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_m    <= 1'b1;
      host_s    <= 1'b1;
      host_prev <= 1'b1;
      port_m    <= '1;
      port_s    <= '1;
      port_prev <= '1;
      sel_m     <= '0;
      sel_s     <= '0;
    end else begin
      host_m    <= host_rx_i;
      host_s    <= host_m;
      host_prev <= host_s;
      port_m    <= port_rx_i;
      port_s    <= port_m;
      port_prev <= port_s;
      sel_m     <= sel_i;
      sel_s     <= sel_m;
    end
  end

  assign conn      = line_of(cur, port_s);
  assign conn_prev = line_of(cur, port_prev);
  assign both_idle = host_s & conn;
  assign fall      = (host_prev & ~host_s) | (conn_prev & ~conn);

  // Next-state logic for the switch FSM and its counters.
  always_comb begin
    state_n   = state;
    cur_n     = cur;
    pending_n = pending;
    idle_n    = idle_cnt;
    gap_n     = gap_cnt;
    case (state)
      CONNECTED: begin
        if (sel_s != cur) begin
          pending_n = sel_s;
          idle_n    = '0;
          state_n   = DRAIN;
        end
      end
      DRAIN: begin
        pending_n = sel_s;
        if (sel_s == cur) begin
          state_n = CONNECTED;
        end else if (both_idle && idle_cnt == IW'(IDLE_CYCLES - 1)) begin
          state_n = GAP;
          gap_n   = '0;
        end else if (both_idle) begin
          if (idle_cnt != IW'(IDLE_CYCLES)) idle_n = idle_cnt + IW'(1);
        end else begin
          idle_n = '0;
        end
      end
      GAP: begin
        pending_n = sel_s;
        if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
          cur_n   = pending;
          state_n = CONNECTED;
        end else if (gap_cnt != GW'(GAP_CYCLES)) begin
          gap_n = gap_cnt + GW'(1);
        end
      end
      default: state_n = CONNECTED;
    endcase
  end

  // Activity stretcher: reload on a falling edge of the bridged lines, cleared entering GAP.
  always_comb begin
    act_n = act_cnt;
    if (state_n == GAP && state != GAP) begin
      act_n = '0;
    end else if (state != GAP && fall) begin
      act_n = AW'(ACT_CYCLES);
    end else if (act_cnt != '0) begin
      act_n = act_cnt - AW'(1);
    end
  end

  // Output data computed from the next state so the forced-high window matches GAP exactly.
  always_comb begin
    host_tx_n = 1'b1;
    port_tx_n = '1;
    if (state_n != GAP) begin
      host_tx_n = line_of(cur_n, port_s);
      for (int k = 0; k < N_PORTS; k++) begin
        if (cur_n == SEL_W'(k)) port_tx_n[k] = host_s;
      end
    end
  end

  // State, counters and registered data outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CONNECTED;
      cur       <= '0;
      pending   <= '0;
      idle_cnt  <= '0;
      gap_cnt   <= '0;
      act_cnt   <= '0;
      host_tx_o <= 1'b1;
      port_tx_o <= '1;
    end else begin
      state     <= state_n;
      cur       <= cur_n;
      pending   <= pending_n;
      idle_cnt  <= idle_n;
      gap_cnt   <= gap_n;
      act_cnt   <= act_n;
      host_tx_o <= host_tx_n;
      port_tx_o <= port_tx_n;
    end
  end

  assign cur_o       = cur;
  assign cur_valid_o = (32'(cur) < N_PORTS);
  assign busy_o      = (state != CONNECTED);
  assign act_o       = (act_cnt != '0);

endmodule
